dap_cmd_dispatch: RTL and testbench
===================================

Name: dap_cmd_dispatch

Overview:
- Upstream stage of the DAP command engines (SWJ/SWD sequence, Transfer, TransferBlock, ...).
- Pops one USB command packet per command from a byte stream and decodes the first byte (command ID).
- Asserts the one-hot start bit of the matching engine and feeds it the remaining packet bytes over the dap_in_tvalid/tready/tdata interface.
- When the engine reports done, drains any unread bytes to the packet end and issues a response-ready handshake to the response packer.

Parameters:
- CMD_NUM, 8, number of command engines; width of start/done/dap_in_tready.
- CMD_IDS, 64'h0, packed table of CMD_NUM 8-bit command IDs; slot i = CMD_IDS[8*i+7:8*i].
- TIMEOUT, 32'd0, max clk cycles from start to done; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- s_tdata  in  8  packet byte from the USB OUT FIFO.
- s_tvalid  in  1  byte valid.
- s_tlast  in  1  last byte of packet.
- s_tready  out  1  byte consumed this cycle.
- dap_in_tvalid  out  1  byte available to the selected engine.
- dap_in_tdata  out  8  byte to engines; equals s_tdata.
- dap_in_tready  in  CMD_NUM  per-engine read request.
- start  out  CMD_NUM  one-hot engine start, held until done.
- done  in  CMD_NUM  per-engine completion.
- resp_valid  out  1  response ready for the packer.
- resp_ready  in  1  packer accepted the response.
- resp_sel  out  $clog2(CMD_NUM)  engine index of the response.
- resp_err  out  2  0 ok, 1 unknown command, 2 timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; sel 0; last_seen 0; timer 0. Reset mid-packet abandons the packet with no drain; upstream must flush it.
- IDLE:
  - s_tready = s_tvalid.
  - On accept, compare s_tdata against every CMD_IDS slot; the lowest matching index wins.
  - last_seen <= s_tlast.
  - Match: sel <= index, start[index] <= 1 on the next edge, state RUN.
  - No match: resp_err <= 1, state DRAIN.
- RUN:
  - dap_in_tvalid = s_tvalid & ~last_seen.
  - s_tready = dap_in_tvalid & dap_in_tready[sel] (combinational; one byte per cycle).
  - Bytes presented to other engines are ignored.
  - Accepting a byte with s_tlast sets last_seen; after that, dap_in_tvalid stays 0 and the engine starves until done or timeout.
  - done[sel] = 1: start <= 0, state DRAIN. This takes priority over a byte accepted in the same cycle, which is still counted.
  - Timer increments each RUN cycle. If TIMEOUT != 0 and timer reaches TIMEOUT without done: start <= 0, resp_err <= 2, state DRAIN.
- DRAIN:
  - If last_seen = 1, go to RESP immediately.
  - Otherwise s_tready = s_tvalid and bytes are discarded until a byte with s_tlast is accepted, then RESP.
  - dap_in_tvalid = 0.
- RESP:
  - resp_valid = 1; resp_sel and resp_err stay stable.
  - On resp_valid & resp_ready: clear resp_err, timer and last_seen; state IDLE.
  - s_tready = 0, so the next packet waits.
- Latency:
  - Command byte accept to start high: 1 cycle.
  - done to start low: 1 cycle.
  - Packet end (already seen) to resp_valid: 1 cycle after DRAIN entry.
- A done that is not from sel, or any done outside RUN, is ignored.
- A single-byte packet (ID with tlast) still starts the engine; the engine then receives no bytes.
- Timer is 32-bit and saturates; it never wraps.

Test Plan:
- CMD_IDS slot1=0x1D, slot0=0x12. Packet {0x1D,0x01,0x02,tlast}; engine reads both bytes then pulses done → start[1] high 1 cycle after accept; dap_in_tdata 0x01 then 0x02; resp_valid with resp_sel=1, resp_err=0; s_tready=0 until resp_ready.
- Packet {0x12,0xAA,0xBB,0xCC,tlast}; engine reads 1 byte then done → start[0] drops next cycle; 0xBB and 0xCC drained with dap_in_tvalid=0; resp after the 0xCC accept.
- Packet {0x55,0x00,tlast} with no matching ID → start stays 0; both bytes consumed; resp_err=1.
- TIMEOUT=100, packet {0x12,tlast}, engine never done → start[0] clears after 100 RUN cycles; resp_err=2, resp_sel=0.
- Back-to-back packets with resp_ready held low 10 cycles → second command byte not accepted until the handshake; then start toggles for the second engine.
- Assert reset during RUN → start, s_tready, dap_in_tvalid and resp_valid go to 0 asynchronously; the next packet decodes normally.

Source files
------------

// File: rtl/dap_cmd_dispatch.sv
// DAP command dispatcher: decodes the first byte of each USB command packet,
// starts the matching engine, streams the rest of the packet to it, then drains and responds.
module dap_cmd_dispatch #(
    parameter int          CMD_NUM = 8,
    parameter logic [63:0] CMD_IDS = 64'h0,
    parameter logic [31:0] TIMEOUT = 32'd0,
    localparam int         SEL_W   = (CMD_NUM > 1) ? $clog2(CMD_NUM) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         s_tdata,
    input  logic               s_tvalid,
    input  logic               s_tlast,
    output logic               s_tready,
    output logic               dap_in_tvalid,
    output logic [7:0]         dap_in_tdata,
    input  logic [CMD_NUM-1:0] dap_in_tready,
    output logic [CMD_NUM-1:0] start,
    input  logic [CMD_NUM-1:0] done,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [SEL_W-1:0]   resp_sel,
    output logic [1:0]         resp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_UNKNOWN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [CMD_NUM-1:0] start_reg, start_next;
    logic               last_seen_reg, last_seen_next;
    logic [31:0]        timer_reg, timer_next;
    logic [1:0]         resp_err_reg, resp_err_next;

    logic [CMD_NUM-1:0] hit;
    logic               match;
    logic [SEL_W-1:0]   match_idx;
    logic [31:0]        timer_sat;
    logic               ready_int;
    logic               in_valid;

    // One comparator per engine slot against the incoming command byte.
    generate
        for (genvar gi = 0; gi < CMD_NUM; gi++) begin : g_id_cmp
            assign hit[gi] = (s_tdata == CMD_IDS[8*gi +: 8]);
        end
    endgenerate

    // Scan from the top down so the lowest matching slot wins.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = CMD_NUM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match     = 1'b1;
                match_idx = SEL_W'(i);
            end
        end
    end

    assign timer_sat = (timer_reg == 32'hFFFF_FFFF) ? timer_reg : timer_reg + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            start_reg     <= '0;
            last_seen_reg <= 1'b0;
            timer_reg     <= '0;
            resp_err_reg  <= ERR_OK;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            start_reg     <= start_next;
            last_seen_reg <= last_seen_next;
            timer_reg     <= timer_next;
            resp_err_reg  <= resp_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        start_next     = start_reg;
        last_seen_next = last_seen_reg;
        timer_next     = timer_reg;
        resp_err_next  = resp_err_reg;
        ready_int      = 1'b0;
        in_valid       = 1'b0;
        resp_valid     = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_int = s_tvalid;
                if (s_tvalid) begin
                    last_seen_next = s_tlast;
                    if (match) begin
                        sel_next              = match_idx;
                        start_next            = '0;
                        start_next[match_idx] = 1'b1;
                        state_next            = RUN;
                    end else begin
                        resp_err_next = ERR_UNKNOWN;
                        state_next    = DRAIN;
                    end
                end
            end

            RUN: begin
                // Once the packet end has been handed over, the engine starves.
                in_valid   = s_tvalid & ~last_seen_reg;
                ready_int  = in_valid & dap_in_tready[sel_reg];
                timer_next = timer_sat;
                if (ready_int && s_tlast) begin
                    last_seen_next = 1'b1;
                end
                if (done[sel_reg]) begin
                    start_next = '0;
                    state_next = DRAIN;
                end else if ((TIMEOUT != 32'd0) && (timer_sat >= TIMEOUT)) begin
                    start_next    = '0;
                    resp_err_next = ERR_TIMEOUT;
                    state_next    = DRAIN;
                end
            end

            DRAIN: begin
                if (last_seen_reg) begin
                    state_next = RESP;
                end else begin
                    ready_int = s_tvalid;
                    if (s_tvalid && s_tlast) begin
                        state_next = RESP;
                    end
                end
            end

            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    resp_err_next  = ERR_OK;
                    timer_next     = '0;
                    last_seen_next = 1'b0;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Gate with reset so nothing is consumed while reset is held.
    assign s_tready      = ready_int & ~reset;
    assign dap_in_tvalid = in_valid;
    assign dap_in_tdata  = s_tdata;
    assign start         = start_reg;
    assign resp_sel      = sel_reg;
    assign resp_err      = resp_err_reg;

endmodule

// File: tb/tb_dap_cmd_dispatch.sv
// Directed bench for dap_cmd_dispatch: decode, streaming, drain, unknown ID,
// timeout, back-to-back response stall and asynchronous reset.
module tb_dap_cmd_dispatch;

    localparam int CMD_NUM = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         s_tdata;
    logic               s_tvalid;
    logic               s_tlast;
    logic               s_tready;
    logic               dap_in_tvalid;
    logic [7:0]         dap_in_tdata;
    logic [CMD_NUM-1:0] dap_in_tready;
    logic [CMD_NUM-1:0] start;
    logic [CMD_NUM-1:0] done;
    logic               resp_valid;
    logic               resp_ready;
    logic [1:0]         resp_sel;
    logic [1:0]         resp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // slot0=0x12, slot1=0x1D, slot2=0x60, slot3=0x60 (duplicate: slot2 must win)
    dap_cmd_dispatch #(
        .CMD_NUM (CMD_NUM),
        .CMD_IDS (64'h0000_0000_6060_1D12),
        .TIMEOUT (32'd100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .dap_in_tvalid (dap_in_tvalid),
        .dap_in_tdata  (dap_in_tdata),
        .dap_in_tready (dap_in_tready),
        .start         (start),
        .done          (done),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_sel      (resp_sel),
        .resp_err      (resp_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; resp_ready = 1'b0; done = '0; dap_in_tready = '0;
        drive(1'b1, 8'h12, 1'b0);
        step(); step();
        total++;
        if (start !== 4'b0000) begin bad++; $display("FAIL reset_start actual=%b required=0000", start); end
        total++;
        if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_s_tready actual=%b required=0", s_tready); end
        total++;
        if (resp_valid !== 1'b0 || resp_err !== 2'd0 || resp_sel !== 2'd0 || dap_in_tvalid !== 1'b0) begin
            bad++; $display("FAIL reset_outputs resp_valid=%b resp_err=%0d resp_sel=%0d dap_in_tvalid=%b required all 0",
                            resp_valid, resp_err, resp_sel, dap_in_tvalid);
        end
        s_tvalid = 1'b0;
        reset = 1'b0;
        step();
        $display("reset: done");
    endtask

    task automatic test_basic();
        drive(1'b1, 8'h1D, 1'b0);
        total++;
        if (s_tready !== 1'b1) begin bad++; $display("FAIL basic_cmd_ready actual=%b required=1", s_tready); end
        step();
        total++;
        if (start !== 4'b0010) begin bad++; $display("FAIL basic_start actual=%b required=0010", start); end
        dap_in_tready = 4'b0010;
        drive(1'b1, 8'h01, 1'b0);
        total++;
        if (dap_in_tvalid !== 1'b1 || dap_in_tdata !== 8'h01 || s_tready !== 1'b1) begin
            bad++; $display("FAIL basic_byte0 tvalid=%b tdata=%h tready=%b required 1/01/1", dap_in_tvalid, dap_in_tdata, s_tready);
        end
        step();
        drive(1'b1, 8'h02, 1'b1);
        total++;
        if (dap_in_tvalid !== 1'b1 || dap_in_tdata !== 8'h02 || s_tready !== 1'b1) begin
            bad++; $display("FAIL basic_byte1 tvalid=%b tdata=%h tready=%b required 1/02/1", dap_in_tvalid, dap_in_tdata, s_tready);
        end
        step();
        drive(1'b1, 8'h77, 1'b0);
        total++;
        if (dap_in_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            bad++; $display("FAIL basic_starve tvalid=%b tready=%b required 0/0", dap_in_tvalid, s_tready);
        end
        s_tvalid = 1'b0;
        dap_in_tready = '0;
        done = 4'b0001;
        step();
        total++;
        if (start !== 4'b0010) begin bad++; $display("FAIL basic_foreign_done actual=%b required=0010", start); end
        done = 4'b0010;
        step();
        done = '0;
        total++;
        if (start !== 4'b0000 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL basic_done start=%b resp_valid=%b required 0000/0", start, resp_valid);
        end
        step();
        drive(1'b1, 8'h12, 1'b0);
        total++;
        if (resp_valid !== 1'b1 || resp_sel !== 2'd1 || resp_err !== 2'd0 || s_tready !== 1'b0) begin
            bad++; $display("FAIL basic_resp valid=%b sel=%0d err=%0d tready=%b required 1/1/0/0", resp_valid, resp_sel, resp_err, s_tready);
        end
        s_tvalid = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        total++;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL basic_resp_clear actual=%b required=0", resp_valid); end
        $display("basic: pkt 1D 01 02 done");
    endtask

    task automatic test_drain();
        drive(1'b1, 8'h12, 1'b0);
        step();
        total++;
        if (start !== 4'b0001) begin bad++; $display("FAIL drain_start actual=%b required=0001", start); end
        dap_in_tready = 4'b0001;
        drive(1'b1, 8'hAA, 1'b0);
        step();
        dap_in_tready = '0;
        done = 4'b0001;
        drive(1'b1, 8'hBB, 1'b0);
        total++;
        if (dap_in_tvalid !== 1'b1 || s_tready !== 1'b0) begin
            bad++; $display("FAIL drain_hold tvalid=%b tready=%b required 1/0", dap_in_tvalid, s_tready);
        end
        step();
        done = '0;
        #1;
        total++;
        if (start !== 4'b0000 || dap_in_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            bad++; $display("FAIL drain_bb start=%b tvalid=%b tready=%b required 0000/0/1", start, dap_in_tvalid, s_tready);
        end
        step();
        drive(1'b1, 8'hCC, 1'b1);
        total++;
        if (dap_in_tvalid !== 1'b0 || s_tready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL drain_cc tvalid=%b tready=%b resp_valid=%b required 0/1/0", dap_in_tvalid, s_tready, resp_valid);
        end
        step();
        s_tvalid = 1'b0;
        total++;
        if (resp_valid !== 1'b1 || resp_sel !== 2'd0 || resp_err !== 2'd0) begin
            bad++; $display("FAIL drain_resp valid=%b sel=%0d err=%0d required 1/0/0", resp_valid, resp_sel, resp_err);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        $display("drain: pkt 12 AA BB CC done");
    endtask

    task automatic test_unknown();
        drive(1'b1, 8'h55, 1'b0);
        total++;
        if (s_tready !== 1'b1) begin bad++; $display("FAIL unk_cmd_ready actual=%b required=1", s_tready); end
        step();
        drive(1'b1, 8'h00, 1'b1);
        total++;
        if (start !== 4'b0000 || resp_err !== 2'd1 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL unk_decode start=%b err=%0d valid=%b required 0000/1/0", start, resp_err, resp_valid);
        end
        total++;
        if (s_tready !== 1'b1 || dap_in_tvalid !== 1'b0) begin
            bad++; $display("FAIL unk_drain tready=%b tvalid=%b required 1/0", s_tready, dap_in_tvalid);
        end
        step();
        s_tvalid = 1'b0;
        total++;
        if (resp_valid !== 1'b1 || resp_err !== 2'd1) begin
            bad++; $display("FAIL unk_resp valid=%b err=%0d required 1/1", resp_valid, resp_err);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        total++;
        if (resp_err !== 2'd0) begin bad++; $display("FAIL unk_err_clear actual=%0d required=0", resp_err); end
        $display("unknown: pkt 55 00 done");
    endtask

    task automatic test_timeout();
        int cnt = 0;
        drive(1'b1, 8'h12, 1'b1);
        step();
        dap_in_tready = 4'b0001;
        drive(1'b1, 8'h99, 1'b0);
        total++;
        if (dap_in_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            bad++; $display("FAIL to_starve tvalid=%b tready=%b required 0/0", dap_in_tvalid, s_tready);
        end
        s_tvalid = 1'b0;
        dap_in_tready = '0;
        while (start[0] === 1'b1 && cnt < 200) begin
            cnt++;
            step();
        end
        total++;
        if (cnt != 100) begin bad++; $display("FAIL to_cycles actual=%0d required=100", cnt); end
        total++;
        if (resp_err !== 2'd2 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL to_err err=%0d valid=%b required 2/0", resp_err, resp_valid);
        end
        step();
        total++;
        if (resp_valid !== 1'b1 || resp_err !== 2'd2 || resp_sel !== 2'd0) begin
            bad++; $display("FAIL to_resp valid=%b err=%0d sel=%0d required 1/2/0", resp_valid, resp_err, resp_sel);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        $display("timeout: pkt 12 start cycles=%0d", cnt);
    endtask

    task automatic test_back_to_back();
        int stalled = 0;
        drive(1'b1, 8'h60, 1'b1);
        step();
        total++;
        if (start !== 4'b0100) begin bad++; $display("FAIL b2b_lowest_slot actual=%b required=0100", start); end
        drive(1'b1, 8'h1D, 1'b1);
        done = 4'b0100;
        step();
        done = '0;
        step();
        for (int i = 0; i < 10; i++) begin
            if (s_tready !== 1'b0 || resp_valid !== 1'b1) stalled++;
            step();
        end
        total++;
        if (stalled != 0) begin bad++; $display("FAIL b2b_stall bad_cycles=%0d required=0", stalled); end
        total++;
        if (resp_sel !== 2'd2 || start !== 4'b0000) begin
            bad++; $display("FAIL b2b_resp sel=%0d start=%b required 2/0000", resp_sel, start);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        #1;
        total++;
        if (s_tready !== 1'b1 || start !== 4'b0000) begin
            bad++; $display("FAIL b2b_second_ready tready=%b start=%b required 1/0000", s_tready, start);
        end
        step();
        s_tvalid = 1'b0;
        total++;
        if (start !== 4'b0010) begin bad++; $display("FAIL b2b_second_start actual=%b required=0010", start); end
        done = 4'b0010;
        step();
        done = '0;
        step();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        $display("back_to_back: pkt 60 then 1D done");
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'h12, 1'b0);
        step();
        dap_in_tready = 4'b0001;
        drive(1'b1, 8'h33, 1'b0);
        total++;
        if (dap_in_tvalid !== 1'b1 || start !== 4'b0001) begin
            bad++; $display("FAIL ar_pre tvalid=%b start=%b required 1/0001", dap_in_tvalid, start);
        end
        reset = 1'b1;
        #1;
        total++;
        if (start !== 4'b0000 || s_tready !== 1'b0 || dap_in_tvalid !== 1'b0 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL ar_async start=%b tready=%b tvalid=%b resp_valid=%b required all 0",
                            start, s_tready, dap_in_tvalid, resp_valid);
        end
        s_tvalid = 1'b0;
        dap_in_tready = '0;
        #1;
        reset = 1'b0;
        step();
        drive(1'b1, 8'h1D, 1'b1);
        step();
        s_tvalid = 1'b0;
        total++;
        if (start !== 4'b0010) begin bad++; $display("FAIL ar_next_start actual=%b required=0010", start); end
        done = 4'b0010;
        step();
        done = '0;
        step();
        total++;
        if (resp_valid !== 1'b1 || resp_sel !== 2'd1 || resp_err !== 2'd0) begin
            bad++; $display("FAIL ar_next_resp valid=%b sel=%0d err=%0d required 1/1/0", resp_valid, resp_sel, resp_err);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        $display("async_reset: pkt 12 abandoned, pkt 1D done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drain();
        test_unknown();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
